// File: rtl/eq_pkg.sv
// Shared equalizer definitions.
//   NR_EQ_BAND_COEFF  coefficients per biquad band
//   A0..B2            coefficient offsets inside a band
//   clog2()           address-width helper for constant expressions
//   eq_unity()        unity coefficient for an S3.(w-4) format
//   cf_state_e        coefficient-bank commit FSM states
package eq_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  localparam int A0 = 0;
  localparam int A1 = 1;
  localparam int A2 = 2;
  localparam int B1 = 3;
  localparam int B2 = 4;

  // Unity for the default 32-bit coefficient width.
  localparam logic [31:0] EQ_UNITY = 32'h1000_0000;

  // Never returns less than 1 so it can size a port directly.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // 1.0 in S3.(w-4): three integer bits above the binary point plus sign.
  function automatic logic [63:0] eq_unity(input int w);
    return 64'd1 << (w - 4);
  endfunction

  typedef enum logic [1:0] {
    CF_IDLE,
    CF_PEND,
    CF_COPY
  } cf_state_e;

endpackage

// File: rtl/eq_coeff_dpram.sv
// True dual-port coefficient RAM, one per bank.
//   addr_a/q_a       port A: equalizer read, registered, read-first
//   we_b/addr_b/d_b  port B: host write or copy write
//   q_b              port B registered read (copy source)
// Contents are not reset; they power up as a passthrough table
// (every a0 = unity, all other coefficients 0).
// Out-of-range addresses read 0 and never write.
module eq_coeff_dpram import eq_pkg::*; #(
  parameter int DEPTH  = 160,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [WIDTH-1:0]  q_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  d_b,
  output logic [WIDTH-1:0]  q_b
);

  localparam logic [WIDTH-1:0] UNITY = WIDTH'(eq_unity(WIDTH));

  typedef logic [DEPTH-1:0][WIDTH-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++)
      m[i] = ((i % NR_EQ_BAND_COEFF) == A0) ? UNITY : '0;
    return m;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction

  mem_t mem = init_mem();

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    q_a <= in_range(addr_a) ? mem[addr_a] : '0;
    q_b <= in_range(addr_b) ? mem[addr_b] : '0;
    if (we_b && in_range(addr_b))
      mem[addr_b] <= d_b;
  end

endmodule

// File: rtl/eq_coeff_bank.sv
// Double-buffered equalizer coefficient store.
//   clk, rst                 clock, async active-high reset
//   eq_coeff_addr/eq_coeff   equalizer read port, latency 1, active bank
//   eq_idle                  equalizer has no sample in flight
//   s_cf_d/addr/dv/dr        host write stream into the shadow bank
//   cf_commit                request to swap active/shadow
//   cf_busy                  commit pending or shadow re-sync running
//   cf_bank                  index of the active bank
//   cf_addr_err              one-cycle pulse on an out-of-range host write
// A commit waits in PEND for eq_idle, flips the bank, then COPY streams the
// new active bank into the new shadow so the host can do partial updates.
module eq_coeff_bank import eq_pkg::*; #(
  parameter  int NR_CHANNELS    = 4,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int ADDR_W         = clog2(NR_EQ_COEFF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                      eq_idle,
  input  logic [EQ_COEFF_WIDTH-1:0] s_cf_d,
  input  logic [ADDR_W-1:0]         s_cf_addr,
  input  logic                      s_cf_dv,
  output logic                      s_cf_dr,
  input  logic                      cf_commit,
  output logic                      cf_busy,
  output logic                      cf_bank,
  output logic                      cf_addr_err
);

  localparam int               CNT_W    = clog2(NR_EQ_COEFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NR_EQ_COEFF);

  cf_state_e state, state_nxt;
  logic      toggle;

  logic [CNT_W-1:0] copy_cnt;
  logic             bank_q;
  logic             rd_vld, rd_bank;

  logic host_acc, host_in_range, host_wr;

  logic [1:0]                     we_b;
  logic [1:0][ADDR_W-1:0]         addr_b;
  logic [1:0][EQ_COEFF_WIDTH-1:0] d_b, q_a, q_b;
  logic [EQ_COEFF_WIDTH-1:0]      copy_data;

  // Host interface
  assign host_in_range = {1'b0, s_cf_addr} < (ADDR_W+1)'(NR_EQ_COEFF);
  assign host_acc      = s_cf_dv && (state == CF_IDLE);
  assign host_wr       = host_acc && host_in_range;

  // State resets to IDLE, so ready is also masked while rst is held.
  assign s_cf_dr = (state == CF_IDLE) && !rst;
  assign cf_busy = (state != CF_IDLE);
  assign cf_bank = bank_q;

  // Commit FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CF_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    toggle    = 1'b0;
    case (state)
      CF_IDLE: if (cf_commit) state_nxt = CF_PEND;
      CF_PEND: if (eq_idle) begin
        toggle    = 1'b1;
        state_nxt = CF_COPY;
      end
      // copy_cnt == CNT_LAST is the final write-only cycle.
      CF_COPY: if (copy_cnt == CNT_LAST) state_nxt = CF_IDLE;
      default: state_nxt = CF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q      <= 1'b0;
      copy_cnt    <= '0;
      cf_addr_err <= 1'b0;
      rd_vld      <= 1'b0;
      rd_bank     <= 1'b0;
    end else begin
      cf_addr_err <= host_acc && !host_in_range;
      rd_vld      <= 1'b1;
      // Remember which bank this cycle's port-A read came from.
      rd_bank     <= bank_q;
      if (toggle) bank_q <= ~bank_q;
      if (state == CF_COPY) copy_cnt <= copy_cnt + 1'b1;
      else                  copy_cnt <= '0;
    end
  end

  // Port B routing. The active bank's port B only ever reads copy_cnt; the
  // shadow's port B takes host writes in IDLE and the delayed copy write in
  // COPY (address copy_cnt-1, data read from the active bank last cycle).
  assign copy_data = q_b[bank_q];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we_b[b]   = 1'b0;
      addr_b[b] = '0;
      d_b[b]    = '0;
      if (bank_q == 1'(b)) begin
        addr_b[b] = ADDR_W'(copy_cnt);
      end else if (state == CF_COPY) begin
        we_b[b]   = (copy_cnt != '0);
        addr_b[b] = ADDR_W'(copy_cnt - 1'b1);
        d_b[b]    = copy_data;
      end else begin
        we_b[b]   = host_wr;
        addr_b[b] = s_cf_addr;
        d_b[b]    = s_cf_d;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    eq_coeff_dpram #(
      .DEPTH  (NR_EQ_COEFF),
      .WIDTH  (EQ_COEFF_WIDTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk    (clk),
      .addr_a (eq_coeff_addr),
      .q_a    (q_a[g]),
      .we_b   (we_b[g]),
      .addr_b (addr_b[g]),
      .d_b    (d_b[g]),
      .q_b    (q_b[g])
    );
  end

  // Forced to 0 straight out of reset; RAM output registers have no reset.
  assign eq_coeff = rd_vld ? q_a[rd_bank] : '0;

endmodule

// File: tb/tb_eq_coeff_bank.sv
module tb_eq_coeff_bank;

  localparam int N = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eq_coeff_addr;
  logic [31:0] eq_coeff;
  logic        eq_idle;
  logic [31:0] s_cf_d;
  logic [7:0]  s_cf_addr;
  logic        s_cf_dv;
  logic        s_cf_dr;
  logic        cf_commit;
  logic        cf_busy;
  logic        cf_bank;
  logic        cf_addr_err;

  eq_coeff_bank dut (
    .clk           (clk),
    .rst           (rst),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff),
    .eq_idle       (eq_idle),
    .s_cf_d        (s_cf_d),
    .s_cf_addr     (s_cf_addr),
    .s_cf_dv       (s_cf_dv),
    .s_cf_dr       (s_cf_dr),
    .cf_commit     (cf_commit),
    .cf_busy       (cf_busy),
    .cf_bank       (cf_bank),
    .cf_addr_err   (cf_addr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: two plain coefficient tables and which one is active.
  logic [31:0] mem [2][N];
  bit          mdl_bank;

  typedef struct {
    int          addr;
    logic [31:0] exp;
  } rd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mref(input int a);
    return (a < N) ? mem[mdl_bank][a] : 32'h0;
  endfunction

  task automatic read_chk(input string name, input int a);
    logic [31:0] exp;
    eq_coeff_addr = 8'(a);
    exp = mref(a);
    tick();
    chk(name, eq_coeff, exp);
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    s_cf_dv   = 1'b1;
    s_cf_addr = 8'(a);
    s_cf_d    = d;
    if (a < N) mem[!mdl_bank][a] = d;
    tick();
    s_cf_dv = 1'b0;
    chk("addr_err", {31'b0, cf_addr_err}, {31'b0, (a >= N)});
  endtask

  task automatic sync_shadow();
    for (int i = 0; i < N; i++) mem[!mdl_bank][i] = mem[mdl_bank][i];
  endtask

  // Commit with eq_idle high, optionally with a host write in the same cycle.
  // Port A is exercised throughout PEND/COPY.
  task automatic commit(input bit wr, input int wa, input logic [31:0] wd);
    int n;
    int a;
    logic [31:0] exp;
    cf_commit = 1'b1;
    if (wr) begin
      s_cf_dv   = 1'b1;
      s_cf_addr = 8'(wa);
      s_cf_d    = wd;
      if (wa < N) mem[!mdl_bank][wa] = wd;
    end
    tick();
    cf_commit = 1'b0;
    s_cf_dv   = 1'b0;
    n = 0;
    while (cf_busy && n < 400) begin
      n++;
      if (n == 2) mdl_bank = !mdl_bank;
      if (n <= 2) begin
        chk("commit_bank", {31'b0, cf_bank}, {31'b0, mdl_bank});
        chk("commit_dr", {31'b0, s_cf_dr}, 32'h0);
      end
      a = $urandom_range(0, 170);
      eq_coeff_addr = 8'(a);
      exp = mref(a);
      tick();
      if (n >= 2) chk("copy_rd", eq_coeff, exp);
    end
    chk("busy_len", n, 162);
    sync_shadow();
  endtask

  rd_vec_t rst_vec[$];

  initial begin
    int n;
    int a;

    for (int i = 0; i < N; i++) begin
      mem[0][i] = (i % 5 == 0) ? 32'h1000_0000 : 32'h0;
      mem[1][i] = mem[0][i];
    end
    mdl_bank = 1'b0;

    rst = 1'b1; eq_idle = 1'b1; cf_commit = 1'b0; s_cf_dv = 1'b0;
    s_cf_addr = '0; s_cf_d = '0; eq_coeff_addr = '0;

    // Reset state
    #3;
    chk("rst_eq_coeff", eq_coeff, 32'h0);
    chk("rst_dr", {31'b0, s_cf_dr}, 32'h0);
    chk("rst_busy", {31'b0, cf_busy}, 32'h0);
    chk("rst_bank", {31'b0, cf_bank}, 32'h0);
    chk("rst_err", {31'b0, cf_addr_err}, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("dr_after_rst", {31'b0, s_cf_dr}, 32'h1);

    // Passthrough power-up contents
    rst_vec = '{'{0, 32'h1000_0000}, '{1, 32'h0}, '{4, 32'h0},
                '{5, 32'h1000_0000}, '{155, 32'h1000_0000}, '{159, 32'h0},
                '{160, 32'h0}, '{255, 32'h0}};
    foreach (rst_vec[i]) begin
      eq_coeff_addr = 8'(rst_vec[i].addr);
      tick();
      chk($sformatf("init_rd_%0d", rst_vec[i].addr), eq_coeff, rst_vec[i].exp);
    end

    // Shadow write is invisible until commit
    host_write(6, 32'h1234_5678);
    read_chk("t2_pre_commit", 6);
    chk("t2_pre_const", eq_coeff, 32'h0);
    commit(1'b0, 0, 32'h0);
    chk("t2_bank", {31'b0, cf_bank}, 32'h1);
    read_chk("t2_post", 6);
    chk("t2_post_const", eq_coeff, 32'h1234_5678);

    // Partial update keeps earlier values through the copy
    host_write(7, 32'h0ABC_DEF0);
    commit(1'b0, 0, 32'h0);
    eq_coeff_addr = 8'd6; tick(); chk("t4_a6", eq_coeff, 32'h1234_5678);
    eq_coeff_addr = 8'd7; tick(); chk("t4_a7", eq_coeff, 32'h0ABC_DEF0);
    eq_coeff_addr = 8'd5; tick(); chk("t4_a5", eq_coeff, 32'h1000_0000);

    // Commit held off by a busy equalizer; extra commits while pending ignored
    eq_idle = 1'b0;
    cf_commit = 1'b1;
    tick();
    cf_commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_bank_hold", {31'b0, cf_bank}, {31'b0, mdl_bank});
      chk("t3_dr", {31'b0, s_cf_dr}, 32'h0);
      chk("t3_busy", {31'b0, cf_busy}, 32'h1);
      cf_commit = (i == 5);
      tick();
    end
    cf_commit = 1'b0;
    eq_idle = 1'b1;
    tick();
    mdl_bank = !mdl_bank;
    chk("t3_toggle", {31'b0, cf_bank}, {31'b0, mdl_bank});
    n = 0;
    while (cf_busy && n < 400) begin n++; tick(); end
    chk("t3_copy_len", n, 161);
    sync_shadow();
    tick();
    chk("t3_no_recommit", {31'b0, cf_busy}, 32'h0);
    read_chk("t3_a6", 6);

    // Out-of-range write and write coincident with commit
    host_write(160, 32'hDEAD_BEEF);
    tick();
    chk("t5_err_pulse_end", {31'b0, cf_addr_err}, 32'h0);
    commit(1'b1, 9, 32'h0555_AAAA);
    eq_coeff_addr = 8'd9; tick(); chk("t5_same_cycle", eq_coeff, 32'h0555_AAAA);
    read_chk("t5_a160", 160);

    // Random rounds against the table model
    for (int r = 0; r < 4; r++) begin
      repeat (20) begin
        a = $urandom_range(0, 175);
        if ($urandom_range(0, 3) == 0) read_chk("rnd_rd", a);
        else                           host_write(a, $urandom);
      end
      commit($urandom_range(0, 1) == 1, $urandom_range(0, 159), $urandom);
      repeat (20) read_chk("rnd_post", $urandom_range(0, 170));
    end

    // Reset in the middle of COPY
    cf_commit = 1'b1;
    tick();
    cf_commit = 1'b0;
    tick();
    repeat (20) tick();
    chk("t6_in_copy", {31'b0, cf_busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_eq_coeff", eq_coeff, 32'h0);
    chk("t6_dr", {31'b0, s_cf_dr}, 32'h0);
    chk("t6_busy", {31'b0, cf_busy}, 32'h0);
    chk("t6_bank", {31'b0, cf_bank}, 32'h0);
    chk("t6_err", {31'b0, cf_addr_err}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    mdl_bank = 1'b0;
    tick();
    chk("t6_dr_release", {31'b0, s_cf_dr}, 32'h1);
    for (int i = 0; i < N; i++) host_write(i, $urandom);
    commit(1'b0, 0, 32'h0);
    for (int i = 0; i < N; i++) read_chk("t6_reload", i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
